pif_timestep_ctrl: RTL

PIF_TIMESTEP_CTRL -- requirements
Module: pif_timestep_ctrl

---
 rtl/pif_timestep_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pif_timestep_ctrl.sv
// -----------------------------------------------------------------------------
// pif_timestep_ctrl
//
// Sequencer for one point-neuron timestep. A start request latches the
// presynaptic spike vector. The controller then reads every synapse weight in
// turn and forwards only the weights of spiking inputs to the neuron adder. It
// waits for the adder pipeline to settle, strobes the membrane update, and
// finally captures the neuron's spike output.
//
// Timeline, with cycle 0 being the cycle in which start is accepted:
//   1 .. N            FEED     wRead=1, wAddr=k (k = cycle-1)
//   2 .. N+1          weightData carries the read data of spiking inputs
//   N+1 .. N+L        DRAIN    adder pipeline settles
//   N+L+1             UPDATE   updateEnable=1
//   N+L+2             CAPTURE  done=1; spikeOut samples spikeBuffer at its end
//
// Ports
//   clk           single rising-edge clock
//   reset         synchronous, active-low reset
//   start         one-cycle timestep request (ignored while busy)
//   spikeIn       presynaptic spike vector, sampled when start is accepted
//   wAddr/wRead   weight memory read port (data returns one cycle later)
//   wData         weight memory read data
//   weightData    gated weight stream to the neuron adder
//   updateEnable  one-cycle membrane update strobe
//   spikeBuffer   neuron spike output
//   spikeOut      neuron spike captured in the last completed timestep
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
//   spikeCount    (PIF_SPIKE_COUNT_EN only) saturating count of output spikes
//
// Build option: define PIF_SPIKE_COUNT_EN to add the spikeCount output.
// -----------------------------------------------------------------------------
module pif_timestep_ctrl #(
    parameter int NUM_INPUT   = 31,
    parameter int DATA_WIDTH  = 16,
    parameter int ADD_LATENCY = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_INPUT-1:0]         spikeIn,
    output logic [$clog2(NUM_INPUT)-1:0] wAddr,
    output logic                         wRead,
    input  logic [DATA_WIDTH-1:0]        wData,
    output logic [DATA_WIDTH-1:0]        weightData,
    output logic                         updateEnable,
    input  logic                         spikeBuffer,
    output logic                         spikeOut,
    output logic                         busy,
`ifdef PIF_SPIKE_COUNT_EN
    output logic [15:0]                  spikeCount,
`endif
    output logic                         done
);

    localparam int AW      = $clog2(NUM_INPUT);
    // One phase counter serves both FEED and DRAIN, so size it for the longer.
    localparam int CNT_MAX = (NUM_INPUT > ADD_LATENCY) ? NUM_INPUT : ADD_LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] FEED_LAST  = CW'(NUM_INPUT - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(ADD_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN,
        UPDATE,
        CAPTURE
    } state_t;

    state_t                 state_q;
    logic [NUM_INPUT-1:0]   spike_q;
    logic [CW-1:0]          phase_q;
    logic [AW-1:0]          waddr_q;
    logic                   wread_q;
    logic                   rd_valid_q;   // wData this cycle answers a FEED read
    logic                   rd_spike_q;   // that read belongs to a spiking input
    logic                   update_q;
    logic                   spike_out_q;
    logic                   busy_q;
    logic                   done_q;
    logic [DATA_WIDTH-1:0]  weight_data_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            spike_q     <= '0;
            phase_q     <= '0;
            waddr_q     <= '0;
            wread_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_spike_q  <= 1'b0;
            update_q    <= 1'b0;
            spike_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            update_q   <= 1'b0;
            done_q     <= 1'b0;
            // The read issued this cycle returns next cycle; remember whether
            // its synapse spiked so the returning word can be gated.
            rd_valid_q <= wread_q;
            rd_spike_q <= wread_q & spike_q[waddr_q];

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FEED;
                        spike_q <= spikeIn;
                        phase_q <= '0;
                        waddr_q <= '0;
                        wread_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                FEED: begin
                    if (phase_q == FEED_LAST) begin
                        state_q <= DRAIN;
                        phase_q <= '0;
                        waddr_q <= '0;
                        wread_q <= 1'b0;
                    end else begin
                        phase_q <= phase_q + CW'(1);
                        waddr_q <= waddr_q + AW'(1);
                    end
                end
                DRAIN: begin
                    if (phase_q == DRAIN_LAST) begin
                        state_q  <= UPDATE;
                        phase_q  <= '0;
                        update_q <= 1'b1;
                    end else begin
                        phase_q <= phase_q + CW'(1);
                    end
                end
                UPDATE: begin
                    state_q <= CAPTURE;
                    done_q  <= 1'b1;
                end
                CAPTURE: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    spike_out_q <= spikeBuffer;
                end
                default: begin
                    state_q <= IDLE;
                    wread_q <= 1'b0;
                    waddr_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pass-through of the returning word, forced to zero for non-spiking
    // synapses and whenever no read is outstanding.
    always_comb begin
        weight_data_d = '0;
        if (rd_valid_q && rd_spike_q) begin
            weight_data_d = wData;
        end
    end

`ifdef PIF_SPIKE_COUNT_EN
    logic [15:0] spike_count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            spike_count_q <= '0;
        end else if (state_q == CAPTURE && spikeBuffer && spike_count_q != 16'hFFFF) begin
            spike_count_q <= spike_count_q + 16'd1;
        end
    end

    assign spikeCount = spike_count_q;
`endif

    assign wAddr        = waddr_q;
    assign wRead        = wread_q;
    assign weightData   = weight_data_d;
    assign updateEnable = update_q;
    assign spikeOut     = spike_out_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
